eeprom_test_seq: RTL
====================

# eeprom_test_seq

Parametrised EEPROM traffic generator and checker that drives the user port of `eeprom_drive` in the I2C clock domain. On `i_start` it performs `P_BURST_NUM` write/read-back burst pairs at consecutive addresses, using a selectable data pattern. It compares every read byte against the expected pattern and reports mismatches, pass/fail and timeout. It replaces the fixed single write/read stimulus in the top level and uses a proper held valid/ready handshake.

## Interface
- `P_DEV_ADDR`, 3'b011: device address bits sent on `o_eeprom_addr`.
- `P_START_ADDR`, 16'd0: byte address of burst 0.
- `P_BURST_LEN`, 8: bytes per burst, 1..255.
- `P_BURST_NUM`, 4: burst pairs per run, 1..65535.
- `P_PATTERN`, 0: 0 = incrementing, 1 = incrementing XOR 8'hA5.
- `P_SEED`, 8'h00: pattern start value.
- `P_TIMEOUT`, 16'd50000: maximum cycles spent waiting on ready or read data.
- `i_clk` in 1: I2C-domain clock (125 kHz).
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: begins a run; sampled only in IDLE.
- `o_busy` out 1: high from start until done.
- `o_done` out 1: one-cycle pulse at end of run.
- `o_err` out 1: sticky mismatch flag, cleared at next start.
- `o_timeout` out 1: sticky timeout flag, cleared at next start.
- `o_err_cnt` out 16: mismatch count, saturates at 16'hFFFF.
- `o_eeprom_addr` out 3: device address.
- `o_user_operation_addr` out 16: operation byte address.
- `o_user_operation_type` out 2: 1 = write, 2 = read.
- `o_user_operation_len` out 8: operation length.
- `o_user_operation_valid` out 1: operation request.
- `i_user_operation_ready` in 1: driver idle and accepting.
- `o_user_write_date` out 8: write byte.
- `o_user_write_valid` / `o_user_write_sop` / `o_user_write_eop` out 1 each: write stream qualifiers.
- `i_user_read_date` in 8: read byte.
- `i_user_read_valid` in 1: read byte strobe.

## Operation
- Expected byte: `exp(b,i) = (P_SEED + b*P_BURST_LEN + i) mod 256`, for burst index `b` and byte index `i`. In pattern 1 this value is XORed with 8'hA5. All arithmetic is 8-bit and wraps.
- Burst address: `P_START_ADDR + b*P_BURST_LEN`, 16-bit, wraps at 16'hFFFF.
- FSM transitions:
  - IDLE -> WR_REQ on `i_start`. Clears `o_err`, `o_timeout`, `o_err_cnt` and `b`.
  - WR_REQ -> WR_DATA on `valid && ready`.
  - WR_DATA -> RD_REQ after the last byte is sent.
  - RD_REQ -> RD_DATA on handshake.
  - RD_DATA -> WR_REQ (with `b+1`) once `P_BURST_LEN` read bytes are received. If `b == P_BURST_NUM-1`, goes to DONE instead.
  - DONE -> IDLE after one cycle, with `o_done` high.
- Request behaviour:
  - `o_user_operation_valid` is high throughout WR_REQ and RD_REQ.
  - Address, type, len and `o_eeprom_addr` are stable while valid is high and zero when valid is low.
  - The request is dropped the cycle after the handshake.
- Write stream: `P_BURST_LEN` consecutive valid cycles, byte `i` = `exp(b,i)`. `sop` is high with byte 0 and `eop` with the last byte. With `P_BURST_LEN = 1`, `sop` and `eop` are high in the same cycle.
- Read check:
  - Each `i_user_read_valid` in RD_DATA compares `i_user_read_date` against `exp(b,i)`.
  - A mismatch sets `o_err` and increments `o_err_cnt`.
  - Read strobes outside RD_DATA are ignored.
- Timeout:
  - A 16-bit counter runs in WR_REQ, RD_REQ and RD_DATA. It reloads on entry to each state and on every read strobe.
  - Reaching `P_TIMEOUT` sets `o_timeout` and goes to DONE. Remaining bursts are abandoned.
- `i_start` while busy is ignored.

## Timing
- Reset values: every output 0, FSM in IDLE, all counters 0. Reset mid-run aborts immediately with no `o_done`.
- `i_start` high at edge N: `o_busy` and `o_user_operation_valid` are high from edge N+1.
- Write handshake at edge H: write `valid` and `sop` with byte 0 from H+1. The last byte is at H+`P_BURST_LEN`. Read request `valid` rises at H+`P_BURST_LEN`+1.
- After the read handshake, no requests are issued until all read bytes arrive.
- Final read byte at edge R: `o_done` is high from R+1 for one cycle, and `o_busy` falls at R+2.
- `o_err_cnt` updates the cycle after the offending strobe.
- Back-to-back read strobes are accepted every cycle.

## Test plan
- Reset asserted mid-write stream, then released: all outputs 0, no `o_done`, FSM idle; a new `i_start` runs normally.
- `P_BURST_LEN=8`, `P_BURST_NUM=1`, echo model: write at addr 0 with data 0..7, `sop` on 0, `eop` on 7; read at addr 0, len 8; `o_done` pulses with `o_err_cnt=0`.
- `P_BURST_NUM=3`, `P_START_ADDR=16'hFFF8`, pattern 1: addresses FFF8, 0000, 0008; data `(0..23)^A5`; no errors.
- Model corrupts byte 3 of burst 1 and byte 0 of burst 2: `o_err=1`, `o_err_cnt=2`, `o_done` pulses.
- `ready` held low 30 cycles before each handshake: `valid` and all fields held stable; `P_BURST_LEN=1` gives `sop`/`eop` in one cycle.
- `P_TIMEOUT=100`, model never returns read data: `o_timeout=1` and `o_done` pulse 100 cycles after the read handshake; a second `i_start` clears the flags.

Source files
------------

// File: rtl/eeprom_test_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// eeprom_test_seq : burst write / read-back traffic generator and checker
//                   for the eeprom_drive user port (I2C clock domain)
// Revision        : 1.0
// ============================================================================
module eeprom_test_seq #(
    parameter logic [2:0]  P_DEV_ADDR   = 3'b011,
    parameter logic [15:0] P_START_ADDR = 16'd0,
    parameter int          P_BURST_LEN  = 8,
    parameter int          P_BURST_NUM  = 4,
    parameter int          P_PATTERN    = 0,
    parameter logic [7:0]  P_SEED       = 8'h00,
    parameter logic [15:0] P_TIMEOUT    = 16'd50000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_timeout,
    output logic [15:0] o_err_cnt,
    output logic [2:0]  o_eeprom_addr,
    output logic [15:0] o_user_operation_addr,
    output logic [1:0]  o_user_operation_type,
    output logic [7:0]  o_user_operation_len,
    output logic        o_user_operation_valid,
    input  logic        i_user_operation_ready,
    output logic [7:0]  o_user_write_date,
    output logic        o_user_write_valid,
    output logic        o_user_write_sop,
    output logic        o_user_write_eop,
    input  logic [7:0]  i_user_read_date,
    input  logic        i_user_read_valid
);

    localparam logic [7:0]  LEN_B      = 8'(P_BURST_LEN);
    localparam logic [7:0]  LAST_BYTE  = 8'(P_BURST_LEN - 1);
    localparam logic [15:0] LEN_W      = 16'(P_BURST_LEN);
    localparam logic [15:0] LAST_BURST = 16'(P_BURST_NUM - 1);
    localparam logic [7:0]  PAT_MASK   = (P_PATTERN == 1) ? 8'hA5 : 8'h00;
    localparam logic [15:0] TMO_LAST   = P_TIMEOUT - 16'd1;
    localparam logic [1:0]  OP_WRITE   = 2'd1;
    localparam logic [1:0]  OP_READ    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] burst_idx;
    logic [15:0] burst_addr;
    logic [7:0]  burst_base;
    logic [7:0]  byte_idx;
    logic [15:0] wait_cnt;
    logic [15:0] err_cnt;
    logic        err_flag;
    logic        tmo_flag;

    logic        req_active;
    logic        handshake;
    logic        rd_strobe;
    logic        last_byte;
    logic        last_burst;
    logic        wait_state;
    logic        tmo_hit;
    logic        run_start;
    logic        burst_adv;
    logic        mismatch;
    logic [7:0]  exp_byte;

    // burst_base already holds seed + b*len, so the byte index is the only add left
    assign exp_byte   = (burst_base + byte_idx) ^ PAT_MASK;
    assign req_active = (state == S_WR_REQ) || (state == S_RD_REQ);
    assign handshake  = req_active && i_user_operation_ready;
    assign rd_strobe  = (state == S_RD_DATA) && i_user_read_valid;
    assign last_byte  = (byte_idx == LAST_BYTE);
    assign last_burst = (burst_idx == LAST_BURST);
    assign wait_state = req_active || (state == S_RD_DATA);
    assign run_start  = (state == S_IDLE) && i_start;
    assign burst_adv  = rd_strobe && last_byte && !last_burst;
    assign mismatch   = rd_strobe && (i_user_read_date != exp_byte);
    // progress on the port always wins over an expiring wait
    assign tmo_hit    = wait_state && !handshake && !rd_strobe && (wait_cnt == TMO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (i_start) next_state = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (handshake)    next_state = S_WR_DATA;
                else if (tmo_hit) next_state = S_DONE;
            end
            S_WR_DATA: begin
                if (last_byte) next_state = S_RD_REQ;
            end
            S_RD_REQ: begin
                if (handshake)    next_state = S_RD_DATA;
                else if (tmo_hit) next_state = S_DONE;
            end
            S_RD_DATA: begin
                if (rd_strobe && last_byte) next_state = last_burst ? S_DONE : S_WR_REQ;
                else if (tmo_hit)           next_state = S_DONE;
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_idx <= 8'd0;
        end else if (handshake) begin
            byte_idx <= 8'd0;
        end else if ((state == S_WR_DATA) || rd_strobe) begin
            byte_idx <= last_byte ? 8'd0 : byte_idx + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            burst_idx  <= 16'd0;
            burst_addr <= 16'd0;
            burst_base <= 8'd0;
        end else if (run_start) begin
            burst_idx  <= 16'd0;
            burst_addr <= P_START_ADDR;
            burst_base <= P_SEED;
        end else if (burst_adv) begin
            burst_idx  <= burst_idx + 16'd1;
            burst_addr <= burst_addr + LEN_W;
            burst_base <= burst_base + LEN_B;
        end
    end

    // Reloads on every state change and every read strobe, counts while waiting
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt <= 16'd0;
        end else if ((next_state != state) || rd_strobe) begin
            wait_cnt <= 16'd0;
        end else if (wait_state) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_flag <= 1'b0;
            tmo_flag <= 1'b0;
            err_cnt  <= 16'd0;
        end else if (run_start) begin
            err_flag <= 1'b0;
            tmo_flag <= 1'b0;
            err_cnt  <= 16'd0;
        end else begin
            if (mismatch) begin
                err_flag <= 1'b1;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
            if (tmo_hit) tmo_flag <= 1'b1;
        end
    end

    assign o_busy                 = (state != S_IDLE);
    assign o_done                 = (state == S_DONE);
    assign o_err                  = err_flag;
    assign o_timeout              = tmo_flag;
    assign o_err_cnt              = err_cnt;

    assign o_user_operation_valid = req_active;
    assign o_eeprom_addr          = req_active ? P_DEV_ADDR : 3'd0;
    assign o_user_operation_addr  = req_active ? burst_addr : 16'd0;
    assign o_user_operation_len   = req_active ? LEN_B : 8'd0;
    assign o_user_operation_type  = (state == S_WR_REQ) ? OP_WRITE :
                                    (state == S_RD_REQ) ? OP_READ  : 2'd0;

    assign o_user_write_valid     = (state == S_WR_DATA);
    assign o_user_write_date      = o_user_write_valid ? exp_byte : 8'd0;
    assign o_user_write_sop       = o_user_write_valid && (byte_idx == 8'd0);
    assign o_user_write_eop       = o_user_write_valid && last_byte;

endmodule
`default_nettype wire
